// File: rtl/mcu_pkg.sv
// mcu_pkg: opcodes, ALU operation codes, FSM state encoding and the
// registered control-word layout shared by the multi-cycle control unit.
package mcu_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_ALUWB  = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_BRANCH = 4'd8,
        S_TRAP   = 4'd9,
        S_EXEC_I = 4'd10
    } state_t;

    // Moore part of the outputs, registered alongside the state.
    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic       memtoread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       pcsrc;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{aluop: ALU_ADD, default: 1'b0};

endpackage

// File: rtl/mcu_alu_decode.sv
// mcu_alu_decode: maps {funct7[5], funct3, is_imm} to an ALU operation
// code and a legality flag. Purely combinational.
import mcu_pkg::*;

module mcu_alu_decode (
    input  logic       funct7_5,
    input  logic [2:0] funct3,
    input  logic       is_imm,
    output logic [3:0] aluop,
    output logic       legal
);

    always_comb begin
        aluop = ALU_BAD;
        legal = 1'b0;
        if (is_imm) begin
            // Immediate forms have no subtract, so funct7 is ignored.
            case (funct3)
                3'b000:  begin aluop = ALU_ADD; legal = 1'b1; end
                3'b110:  begin aluop = ALU_OR;  legal = 1'b1; end
                3'b111:  begin aluop = ALU_AND; legal = 1'b1; end
                default: begin aluop = ALU_BAD; legal = 1'b0; end
            endcase
        end else begin
            case ({funct7_5, funct3})
                4'b1000: begin aluop = ALU_SUB; legal = 1'b1; end
                4'b0000: begin aluop = ALU_ADD; legal = 1'b1; end
                4'b0110: begin aluop = ALU_OR;  legal = 1'b1; end
                4'b0111: begin aluop = ALU_AND; legal = 1'b1; end
                default: begin aluop = ALU_BAD; legal = 1'b0; end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32 multi-cycle FSM sequencer with memory
// handshake, trap state and retired-instruction counter.
// Optional macro MCU_IMM_ARITH_EN enables the OP-IMM (addi/ori/andi) path.
import mcu_pkg::*;

module multicycle_control_unit #(
    parameter int WIDTH   = 32,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   instruction,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [ALUOP_W-1:0] aluop,
    output logic               pcwrite,
    output logic               pcsrc,
    output logic               irwrite,
    output logic               alusrc,
    output logic               memtoread,
    output logic               memwrite,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               illegal,
    output logic [3:0]         state,
    output logic [CNT_W-1:0]   instret
);

    state_t     st;
    state_t     nxt;
    ctrl_t      ctrl;
    ctrl_t      nxt_ctrl;
    logic       retire;
    logic [6:0] opcode;
    logic       is_imm;
    logic [3:0] dec_aluop;
    logic       dec_legal;
    logic       unused_bits;

    assign opcode      = instruction[6:0];
    assign is_imm      = (opcode == OP_IMM);
    assign unused_bits = ^{instruction[WIDTH-1:31], instruction[29:15], instruction[11:7]};

    mcu_alu_decode u_alu_decode (
        .funct7_5 (instruction[30]),
        .funct3   (instruction[14:12]),
        .is_imm   (is_imm),
        .aluop    (dec_aluop),
        .legal    (dec_legal)
    );

    always_comb begin
        nxt    = st;
        retire = 1'b0;
        case (st)
            S_FETCH:  if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:         nxt = S_EXEC_R;
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_BEQ:       nxt = S_BRANCH;
`ifdef MCU_IMM_ARITH_EN
                    OP_IMM:       nxt = S_EXEC_I;
`endif
                    default:      nxt = S_TRAP;
                endcase
            end
            S_EXEC_R: nxt = dec_legal ? S_ALUWB : S_TRAP;
`ifdef MCU_IMM_ARITH_EN
            S_EXEC_I: nxt = dec_legal ? S_ALUWB : S_TRAP;
`endif
            S_ALUWB:  begin nxt = S_FETCH; retire = 1'b1; end
            S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
            S_MEMWB:  begin nxt = S_FETCH; retire = 1'b1; end
            S_MEMWR:  if (mem_ready) begin nxt = S_FETCH; retire = 1'b1; end
            S_BRANCH: begin nxt = S_FETCH; retire = 1'b1; end
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_FETCH;
        endcase
    end

    // Control word for the state being entered, so outputs stay Moore
    // while coming straight from flops.
    always_comb begin
        nxt_ctrl = CTRL_IDLE;
        case (nxt)
            S_FETCH:  nxt_ctrl.memtoread = 1'b1;
            S_EXEC_R: nxt_ctrl.aluop     = dec_aluop;
`ifdef MCU_IMM_ARITH_EN
            S_EXEC_I: begin
                nxt_ctrl.aluop  = dec_aluop;
                nxt_ctrl.alusrc = 1'b1;
            end
`endif
            S_ALUWB:  begin
                nxt_ctrl.aluop    = ctrl.aluop;
                nxt_ctrl.alusrc   = ctrl.alusrc;
                nxt_ctrl.regwrite = 1'b1;
            end
            S_MEMADR: nxt_ctrl.alusrc = 1'b1;
            S_MEMRD:  begin
                nxt_ctrl.memtoread = 1'b1;
                nxt_ctrl.alusrc    = 1'b1;
            end
            S_MEMWB:  begin
                nxt_ctrl.memtoreg = 1'b1;
                nxt_ctrl.regwrite = 1'b1;
            end
            S_MEMWR:  begin
                nxt_ctrl.memwrite = 1'b1;
                nxt_ctrl.alusrc   = 1'b1;
            end
            S_BRANCH: begin
                nxt_ctrl.aluop = ALU_SUB;
                nxt_ctrl.pcsrc = 1'b1;
            end
            S_TRAP:   begin
                nxt_ctrl.aluop   = ALU_BAD;
                nxt_ctrl.illegal = 1'b1;
            end
            default:  nxt_ctrl = CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= S_FETCH;
            ctrl    <= '{aluop: ALU_ADD, memtoread: 1'b1, default: 1'b0};
            instret <= '0;
        end else begin
            st   <= nxt;
            ctrl <= nxt_ctrl;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

    // Enables are masked by rst_n so nothing fires while reset is held,
    // even though the FETCH state itself is already loaded.
    assign aluop     = ALUOP_W'(ctrl.aluop);
    assign alusrc    = ctrl.alusrc    & rst_n;
    assign memtoread = ctrl.memtoread & rst_n;
    assign memwrite  = ctrl.memwrite  & rst_n;
    assign memtoreg  = ctrl.memtoreg  & rst_n;
    assign regwrite  = ctrl.regwrite  & rst_n;
    assign pcsrc     = ctrl.pcsrc     & rst_n;
    assign illegal   = ctrl.illegal   & rst_n;
    assign irwrite   = rst_n & (st == S_FETCH) & mem_ready;
    assign pcwrite   = rst_n & (((st == S_FETCH) & mem_ready) | ((st == S_BRANCH) & zero));
    assign state     = st;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit; counter is narrowed to 4 bits
// so wrap-around is reachable.
module tb_multicycle_control_unit;

    localparam int CNT_W = 4;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EXEC_R = 4'd2, ST_ALUWB = 4'd3;
    localparam logic [3:0] ST_MEMADR = 4'd4, ST_MEMRD = 4'd5, ST_MEMWB = 4'd6, ST_MEMWR = 4'd7;
    localparam logic [3:0] ST_BRANCH = 4'd8, ST_TRAP = 4'd9, ST_EXEC_I = 4'd10;
    localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110, A_BAD = 4'b1111;
    // enables: {pcwrite,pcsrc,irwrite,alusrc,memtoread,memwrite,memtoreg,regwrite,illegal}
    localparam logic [8:0] EN_NONE = 9'h000, EN_FETCH_RDY = 9'h150, EN_FETCH_WAIT = 9'h010;
    localparam logic [8:0] EN_ALUWB = 9'h002, EN_ALUWB_I = 9'h022, EN_MEMADR = 9'h020, EN_MEMRD = 9'h030;
    localparam logic [8:0] EN_MEMWB = 9'h006, EN_MEMWR = 9'h028, EN_BR_T = 9'h180, EN_BR_NT = 9'h080;
    localparam logic [8:0] EN_TRAP = 9'h001, EN_EXEC_I = 9'h020;

    logic             clk, rst_n, zero, mem_ready;
    logic [31:0]      instruction;
    logic [3:0]       aluop, state;
    logic             pcwrite, pcsrc, irwrite, alusrc, memtoread, memwrite, memtoreg, regwrite, illegal;
    logic [CNT_W-1:0] instret;
    logic [16:0]      obs;

    typedef struct {
        logic        mr;
        logic        z;
        logic [16:0] exp;
        logic        ret;
    } step_t;

    step_t            plan[$];
    step_t            sb[$];
    step_t            cur, got;
    logic [CNT_W-1:0] model_ret;
    int               checks, errors;

    multicycle_control_unit #(.WIDTH(32), .ALUOP_W(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
        .aluop(aluop), .pcwrite(pcwrite), .pcsrc(pcsrc), .irwrite(irwrite), .alusrc(alusrc),
        .memtoread(memtoread), .memwrite(memwrite), .memtoreg(memtoreg), .regwrite(regwrite),
        .illegal(illegal), .state(state), .instret(instret)
    );

    assign obs = {state, aluop, pcwrite, pcsrc, irwrite, alusrc, memtoread, memwrite, memtoreg, regwrite, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic p(input logic mr, input logic z, input logic [3:0] st, input logic [3:0] op,
                     input logic [8:0] en, input logic ret);
        step_t s;
        s.mr = mr; s.z = z; s.exp = {st, op, en}; s.ret = ret;
        plan.push_back(s);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; instruction = 32'h0;
        @(negedge clk); #1;
        checks++;
        if (obs !== {ST_FETCH, A_ADD, EN_NONE} || instret !== '0) begin
            errors++;
            $display("FAIL reset: obs=%h instret=%0d required obs=%h instret=0", obs, instret, {ST_FETCH, A_ADD, EN_NONE});
        end
        rst_n = 1'b1; mem_ready = 1'b0; model_ret = '0;
        @(negedge clk);
    endtask

    task automatic test_rtype();
        instruction = 32'h002081B3;
        p(1, 0, ST_FETCH, A_ADD, EN_FETCH_RDY, 0);
        p(1, 0, ST_DECODE, A_ADD, EN_NONE, 0);
        p(1, 0, ST_EXEC_R, A_ADD, EN_NONE, 0);
        p(1, 0, ST_ALUWB, A_ADD, EN_ALUWB, 1);
        p(0, 0, ST_FETCH, A_ADD, EN_FETCH_WAIT, 0);
        while (plan.size() > 0) begin
            cur = plan.pop_front(); mem_ready = cur.mr; zero = cur.z; sb.push_back(cur); #1;
            got = sb.pop_front(); checks++;
            if (obs !== got.exp || instret !== model_ret) begin
                errors++;
                $display("FAIL rtype: obs=%h instret=%0d required obs=%h instret=%0d", obs, instret, got.exp, model_ret);
            end
            if (got.ret) model_ret++;
            @(negedge clk);
        end
    endtask

    task automatic test_load();
        instruction = 32'h0000A183;
        repeat (3) p(0, 0, ST_FETCH, A_ADD, EN_FETCH_WAIT, 0);
        p(1, 0, ST_FETCH, A_ADD, EN_FETCH_RDY, 0);
        p(1, 0, ST_DECODE, A_ADD, EN_NONE, 0);
        p(1, 0, ST_MEMADR, A_ADD, EN_MEMADR, 0);
        repeat (2) p(0, 0, ST_MEMRD, A_ADD, EN_MEMRD, 0);
        p(1, 0, ST_MEMRD, A_ADD, EN_MEMRD, 0);
        p(1, 0, ST_MEMWB, A_ADD, EN_MEMWB, 1);
        p(0, 0, ST_FETCH, A_ADD, EN_FETCH_WAIT, 0);
        while (plan.size() > 0) begin
            cur = plan.pop_front(); mem_ready = cur.mr; zero = cur.z; sb.push_back(cur); #1;
            got = sb.pop_front(); checks++;
            if (obs !== got.exp || instret !== model_ret) begin
                errors++;
                $display("FAIL load: obs=%h instret=%0d required obs=%h instret=%0d", obs, instret, got.exp, model_ret);
            end
            if (got.ret) model_ret++;
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        instruction = 32'h00208063;
        p(1, 1, ST_FETCH, A_ADD, EN_FETCH_RDY, 0);
        p(1, 1, ST_DECODE, A_ADD, EN_NONE, 0);
        p(1, 1, ST_BRANCH, A_SUB, EN_BR_T, 1);
        p(1, 0, ST_FETCH, A_ADD, EN_FETCH_RDY, 0);
        p(1, 0, ST_DECODE, A_ADD, EN_NONE, 0);
        p(1, 0, ST_BRANCH, A_SUB, EN_BR_NT, 1);
        p(0, 0, ST_FETCH, A_ADD, EN_FETCH_WAIT, 0);
        while (plan.size() > 0) begin
            cur = plan.pop_front(); mem_ready = cur.mr; zero = cur.z; sb.push_back(cur); #1;
            got = sb.pop_front(); checks++;
            if (obs !== got.exp || instret !== model_ret) begin
                errors++;
                $display("FAIL branch: obs=%h instret=%0d required obs=%h instret=%0d", obs, instret, got.exp, model_ret);
            end
            if (got.ret) model_ret++;
            @(negedge clk);
        end
    endtask

    task automatic test_store();
        instruction = 32'h0020A023;
        p(1, 0, ST_FETCH, A_ADD, EN_FETCH_RDY, 0);
        p(1, 0, ST_DECODE, A_ADD, EN_NONE, 0);
        p(0, 0, ST_MEMADR, A_ADD, EN_MEMADR, 0);
        repeat (2) p(0, 0, ST_MEMWR, A_ADD, EN_MEMWR, 0);
        p(1, 0, ST_MEMWR, A_ADD, EN_MEMWR, 1);
        p(0, 0, ST_FETCH, A_ADD, EN_FETCH_WAIT, 0);
        while (plan.size() > 0) begin
            cur = plan.pop_front(); mem_ready = cur.mr; zero = cur.z; sb.push_back(cur); #1;
            got = sb.pop_front(); checks++;
            if (obs !== got.exp || instret !== model_ret) begin
                errors++;
                $display("FAIL store: obs=%h instret=%0d required obs=%h instret=%0d", obs, instret, got.exp, model_ret);
            end
            if (got.ret) model_ret++;
            @(negedge clk);
        end
    endtask

    // Back-to-back branches carry the narrowed counter through its wrap.
    task automatic test_back_to_back();
        logic z;
        instruction = 32'h00208063;
        for (int i = 0; i < 12; i++) begin
            z = 1'($urandom_range(0, 1));
            p(1, z, ST_FETCH, A_ADD, EN_FETCH_RDY, 0);
            p(1, z, ST_DECODE, A_ADD, EN_NONE, 0);
            p(1, z, ST_BRANCH, A_SUB, z ? EN_BR_T : EN_BR_NT, 1);
        end
        p(0, 0, ST_FETCH, A_ADD, EN_FETCH_WAIT, 0);
        while (plan.size() > 0) begin
            cur = plan.pop_front(); mem_ready = cur.mr; zero = cur.z; sb.push_back(cur); #1;
            got = sb.pop_front(); checks++;
            if (obs !== got.exp || instret !== model_ret) begin
                errors++;
                $display("FAIL back_to_back: obs=%h instret=%0d required obs=%h instret=%0d", obs, instret, got.exp, model_ret);
            end
            if (got.ret) model_ret++;
            @(negedge clk);
        end
    endtask

    task automatic test_store_abort();
        instruction = 32'h0020A023;
        p(1, 0, ST_FETCH, A_ADD, EN_FETCH_RDY, 0);
        p(1, 0, ST_DECODE, A_ADD, EN_NONE, 0);
        p(0, 0, ST_MEMADR, A_ADD, EN_MEMADR, 0);
        p(0, 0, ST_MEMWR, A_ADD, EN_MEMWR, 0);
        while (plan.size() > 0) begin
            cur = plan.pop_front(); mem_ready = cur.mr; zero = cur.z; sb.push_back(cur); #1;
            got = sb.pop_front(); checks++;
            if (obs !== got.exp || instret !== model_ret) begin
                errors++;
                $display("FAIL store_abort: obs=%h instret=%0d required obs=%h instret=%0d", obs, instret, got.exp, model_ret);
            end
            if (got.ret) model_ret++;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (memwrite !== 1'b0 || state !== ST_FETCH || instret !== '0) begin
            errors++;
            $display("FAIL store_abort_async: memwrite=%b state=%0d instret=%0d required 0 0 0", memwrite, state, instret);
        end
        @(negedge clk);
        rst_n = 1'b1; model_ret = '0;
        p(0, 0, ST_FETCH, A_ADD, EN_FETCH_WAIT, 0);
        p(0, 0, ST_FETCH, A_ADD, EN_FETCH_WAIT, 0);
        while (plan.size() > 0) begin
            cur = plan.pop_front(); mem_ready = cur.mr; zero = cur.z; sb.push_back(cur); #1;
            got = sb.pop_front(); checks++;
            if (obs !== got.exp || instret !== model_ret) begin
                errors++;
                $display("FAIL store_abort_after: obs=%h instret=%0d required obs=%h instret=%0d", obs, instret, got.exp, model_ret);
            end
            if (got.ret) model_ret++;
            @(negedge clk);
        end
    endtask

    // Bad opcode traps from DECODE; bad R-type funct traps from EXEC_R.
    task automatic test_trap(input logic [31:0] word, input logic via_exec);
        instruction = word;
        p(1, 0, ST_FETCH, A_ADD, EN_FETCH_RDY, 0);
        p(1, 0, ST_DECODE, A_ADD, EN_NONE, 0);
        if (via_exec) p(1, 0, ST_EXEC_R, A_BAD, EN_NONE, 0);
        for (int i = 0; i < 20; i++) begin
            logic r;
            r = 1'($urandom_range(0, 1));
            p(r, ~r, ST_TRAP, A_BAD, EN_TRAP, 0);
        end
        while (plan.size() > 0) begin
            cur = plan.pop_front(); mem_ready = cur.mr; zero = cur.z; sb.push_back(cur); #1;
            got = sb.pop_front(); checks++;
            if (obs !== got.exp || instret !== model_ret) begin
                errors++;
                $display("FAIL trap: word=%h obs=%h instret=%0d required obs=%h instret=%0d", word, obs, instret, got.exp, model_ret);
            end
            if (got.ret) model_ret++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== ST_FETCH || instret !== '0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL trap_reset: state=%0d instret=%0d illegal=%b required 0 0 0", state, instret, illegal);
        end
        @(negedge clk);
        rst_n = 1'b1; model_ret = '0;
        @(negedge clk);
    endtask

    task automatic test_imm();
        instruction = 32'h00508093;
        p(1, 0, ST_FETCH, A_ADD, EN_FETCH_RDY, 0);
        p(1, 0, ST_DECODE, A_ADD, EN_NONE, 0);
`ifdef MCU_IMM_ARITH_EN
        p(1, 0, ST_EXEC_I, A_ADD, EN_EXEC_I, 0);
        p(1, 0, ST_ALUWB, A_ADD, EN_ALUWB_I, 1);
        p(0, 0, ST_FETCH, A_ADD, EN_FETCH_WAIT, 0);
`else
        repeat (3) p(1, 0, ST_TRAP, A_BAD, EN_TRAP, 0);
`endif
        while (plan.size() > 0) begin
            cur = plan.pop_front(); mem_ready = cur.mr; zero = cur.z; sb.push_back(cur); #1;
            got = sb.pop_front(); checks++;
            if (obs !== got.exp || instret !== model_ret) begin
                errors++;
                $display("FAIL imm: obs=%h instret=%0d required obs=%h instret=%0d", obs, instret, got.exp, model_ret);
            end
            if (got.ret) model_ret++;
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        test_reset();
        test_rtype();
        test_load();
        test_branch();
        test_store();
        test_back_to_back();
        test_store_abort();
        test_trap(32'h0000007F, 1'b0);
        test_trap(32'h0020D1B3, 1'b1);
        test_imm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
